bp_me_burst_pump_out: RTL and testbench

- Outbound counterpart of the inbound burst pump: accepts header and data beats from a producer FSM and emits a BedRock Stream message (header channel plus data channel with last flag).
- Supplies the FSM with beat count, wrapped beat address, and first/last beat strobes.
- Buffers both output channels, so the FSM never stalls combinationally on downstream ready.
- Sits between cache, memory or I/O engines and the coherence network links.

---
 rtl/bp_me_pkg.sv | 27 ++
 rtl/bp_me_burst_pump_out_chk.sv | 16 +
 rtl/bp_me_pump_fifo_async.sv | 58 +++++
 rtl/bp_me_burst_pump_out.sv | 191 +++++++++++++++++++
 tb/tb_bp_me_burst_pump_out.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_me_pkg.sv
// Shared definitions for the BedRock stream burst pumps (inbound and outbound).
package bp_me_pkg;

    // Header field layout, LSB first: msg_type, size, addr, payload.
    localparam int bp_me_type_width_lp = 4;
    localparam int bp_me_size_width_lp = 3;
    localparam int bp_me_addr_lsb_lp   = bp_me_type_width_lp + bp_me_size_width_lp;

    typedef enum logic [1:0] {
        e_ready    = 2'd0,
        e_burst    = 2'd1,
        e_collapse = 2'd2
    } bp_me_pump_state_e;

    // Beats minus one for a message of 2^size bytes; a sub-beat size still takes one beat.
    function automatic int unsigned bp_me_size_to_beats_m1(input logic [2:0] size,
                                                           input int unsigned stream_bytes_log2);
        int unsigned sz;
        sz = {29'd0, size};
        if (sz >= stream_bytes_log2) begin
            return (32'd1 << (sz - stream_bytes_log2)) - 32'd1;
        end else begin
            return 32'd0;
        end
    endfunction

endpackage

// File: rtl/bp_me_burst_pump_out_chk.sv
// Protocol checker: a stalled first beat must hold valid and a stable header.
module bp_me_burst_pump_out_chk #(
    parameter int header_width_p = 8
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    input logic                      in_ready_state_i,
    input logic                      fsm_v_i,
    input logic                      fsm_ready_and_i,
    input logic [header_width_p-1:0] fsm_base_header_i
);

    a_first_beat_held: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (in_ready_state_i & fsm_v_i & ~fsm_ready_and_i) |=> (fsm_v_i & $stable(fsm_base_header_i)));

endmodule

// File: rtl/bp_me_pump_fifo_async.sv
// Small 1r1w ready/valid buffer with asynchronous active-low reset.
// A full buffer refuses pushes, so push and pop never collide on a full entry.
module bp_me_pump_fifo_async #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_and_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               ready_and_i
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_wptr;
    logic [ptr_w_lp-1:0] r_rptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_push;
    logic                w_pop;

    assign ready_and_o = (r_count != cnt_w_lp'(els_p));
    assign v_o         = (r_count != {cnt_w_lp{1'b0}});
    assign data_o      = r_mem[r_rptr];
    assign w_push      = v_i & ready_and_o;
    assign w_pop       = v_o & ready_and_i;

    // Storage, circular pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                r_mem[i] <= {width_p{1'b0}};
            end
            r_wptr  <= {ptr_w_lp{1'b0}};
            r_rptr  <= {ptr_w_lp{1'b0}};
            r_count <= {cnt_w_lp{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= data_i;
                r_wptr <= (r_wptr == ptr_w_lp'(els_p - 1)) ? {ptr_w_lp{1'b0}} : r_wptr + ptr_w_lp'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == ptr_w_lp'(els_p - 1)) ? {ptr_w_lp{1'b0}} : r_rptr + ptr_w_lp'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + cnt_w_lp'(1);
                2'b01:   r_count <= r_count - cnt_w_lp'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bp_me_burst_pump_out.sv
// Outbound burst pump: turns producer-FSM beats into a buffered BedRock stream
// message (header channel + data channel with last flag), handling N:N bursts
// and N:1 collapse of streamed beats into a single header.
module bp_me_burst_pump_out
    import bp_me_pkg::*;
#(
    parameter int          paddr_width_p       = 40,
    parameter int          stream_data_width_p = 64,
    parameter int          block_width_p       = 512,
    parameter int          payload_width_p     = 16,
    parameter logic [15:0] msg_stream_mask_p   = 16'h0000,
    parameter logic [15:0] fsm_stream_mask_p   = msg_stream_mask_p,
    parameter int          header_els_p        = 2,
    parameter int          data_els_p          = header_els_p * (block_width_p / stream_data_width_p),
    localparam int hdr_w_lp         = payload_width_p + paddr_width_p + bp_me_addr_lsb_lp,
    localparam int stream_bytes_lp  = stream_data_width_p / 8,
    localparam int stream_words_lp  = block_width_p / stream_data_width_p,
    localparam int cnt_w_lp         = (stream_words_lp > 1) ? $clog2(stream_words_lp) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [hdr_w_lp-1:0]            fsm_base_header_i,
    input  logic                           fsm_has_data_i,
    input  logic [stream_data_width_p-1:0] fsm_data_i,
    input  logic                           fsm_v_i,
    output logic                           fsm_ready_and_o,
    output logic [cnt_w_lp-1:0]            fsm_cnt_o,
    output logic [paddr_width_p-1:0]       fsm_addr_o,
    output logic                           fsm_new_o,
    output logic                           fsm_last_o,
    output logic [hdr_w_lp-1:0]            msg_header_o,
    output logic                           msg_header_v_o,
    input  logic                           msg_header_ready_and_i,
    output logic                           msg_has_data_o,
    output logic [stream_data_width_p-1:0] msg_data_o,
    output logic                           msg_data_v_o,
    input  logic                           msg_data_ready_and_i,
    output logic                           msg_last_o
);

    localparam int off_lp = $clog2(stream_bytes_lp);

    bp_me_pump_state_e          r_state;
    logic                       r_live;
    logic [cnt_w_lp-1:0]        r_cnt;
    logic [cnt_w_lp-1:0]        r_size;
    logic [paddr_width_p-1:0]   r_base_addr;

    logic [bp_me_type_width_lp-1:0] w_type;
    logic [bp_me_size_width_lp-1:0] w_size;
    logic [paddr_width_p-1:0]       w_hdr_addr;
    logic [cnt_w_lp-1:0]            w_size_n;
    logic                           w_do_burst;
    logic                           w_do_collapse;
    logic                           w_in_ready;
    logic                           w_hdr_ready;
    logic                           w_data_ready;
    logic                           w_ready;
    logic                           w_fire;
    logic                           w_hdr_push;
    logic                           w_data_push;
    logic [paddr_width_p-1:0]       w_base_addr;
    logic [cnt_w_lp-1:0]            w_mask;
    logic [cnt_w_lp-1:0]            w_word;
    logic [cnt_w_lp-1:0]            w_wrap;

    // Live header decode; only meaningful on the first beat of a message.
    assign w_type        = fsm_base_header_i[bp_me_type_width_lp-1:0];
    assign w_size        = fsm_base_header_i[bp_me_addr_lsb_lp-1:bp_me_type_width_lp];
    assign w_hdr_addr    = fsm_base_header_i[bp_me_addr_lsb_lp+paddr_width_p-1:bp_me_addr_lsb_lp];
    assign w_size_n      = cnt_w_lp'(bp_me_size_to_beats_m1(w_size, off_lp));
    assign w_do_burst    = fsm_stream_mask_p[w_type] & msg_stream_mask_p[w_type]
                         & (w_size_n != {cnt_w_lp{1'b0}});
    assign w_do_collapse = fsm_stream_mask_p[w_type] & ~msg_stream_mask_p[w_type]
                         & (w_size_n != {cnt_w_lp{1'b0}});
    assign w_in_ready    = (r_state == e_ready);

    // Per-state acceptance and last-beat strobe toward the producer FSM.
    always_comb begin
        w_ready    = 1'b0;
        fsm_last_o = 1'b1;
        case (r_state)
            e_ready: begin
                w_ready    = w_hdr_ready & (~fsm_has_data_i | w_data_ready);
                fsm_last_o = ~(w_do_burst | w_do_collapse);
            end
            e_burst: begin
                w_ready    = w_data_ready;
                fsm_last_o = (r_cnt == r_size);
            end
            e_collapse: begin
                w_ready    = 1'b1;
                fsm_last_o = (r_cnt == r_size);
            end
            default: begin
                w_ready    = 1'b0;
                fsm_last_o = 1'b1;
            end
        endcase
    end

    assign fsm_ready_and_o = r_live & w_ready;
    assign fsm_new_o       = w_in_ready;
    assign fsm_cnt_o       = r_cnt;
    assign w_fire          = fsm_v_i & fsm_ready_and_o;
    assign w_hdr_push      = w_fire & w_in_ready;
    assign w_data_push     = w_fire & ((w_in_ready & fsm_has_data_i) | (r_state == e_burst));

    // Wrapped beat address inside the size-aligned window; offset bits only on beat 0.
    assign w_base_addr = w_in_ready ? w_hdr_addr : r_base_addr;
    assign w_mask      = w_in_ready ? w_size_n : r_size;
    assign w_word      = w_base_addr[off_lp+cnt_w_lp-1:off_lp];
    assign w_wrap      = (w_word & ~w_mask) | ((w_word + r_cnt) & w_mask);
    assign fsm_addr_o  = {w_base_addr[paddr_width_p-1:off_lp+cnt_w_lp], w_wrap,
                          (r_cnt == {cnt_w_lp{1'b0}}) ? w_base_addr[off_lp-1:0] : {off_lp{1'b0}}};

    // Message state machine, beat counter and first-beat captures.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= e_ready;
            r_live      <= 1'b0;
            r_cnt       <= {cnt_w_lp{1'b0}};
            r_size      <= {cnt_w_lp{1'b0}};
            r_base_addr <= {paddr_width_p{1'b0}};
        end else begin
            r_live <= 1'b1;
            if (w_fire) begin
                case (r_state)
                    e_ready: begin
                        r_base_addr <= w_hdr_addr;
                        r_size      <= w_size_n;
                        if (w_do_burst) begin
                            r_state <= e_burst;
                            r_cnt   <= cnt_w_lp'(1);
                        end else if (w_do_collapse) begin
                            r_state <= e_collapse;
                            r_cnt   <= cnt_w_lp'(1);
                        end else begin
                            r_state <= e_ready;
                            r_cnt   <= {cnt_w_lp{1'b0}};
                        end
                    end
                    e_burst, e_collapse: begin
                        if (fsm_last_o) begin
                            r_state <= e_ready;
                            r_cnt   <= {cnt_w_lp{1'b0}};
                        end else begin
                            r_cnt   <= r_cnt + cnt_w_lp'(1);
                        end
                    end
                    default: begin
                        r_state <= e_ready;
                        r_cnt   <= {cnt_w_lp{1'b0}};
                    end
                endcase
            end
        end
    end

    bp_me_pump_fifo_async #(.width_p(hdr_w_lp + 1), .els_p(header_els_p)) u_hdr_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .data_i      ({fsm_has_data_i, fsm_base_header_i}),
        .v_i         (w_hdr_push),
        .ready_and_o (w_hdr_ready),
        .data_o      ({msg_has_data_o, msg_header_o}),
        .v_o         (msg_header_v_o),
        .ready_and_i (msg_header_ready_and_i)
    );

    bp_me_pump_fifo_async #(.width_p(stream_data_width_p + 1), .els_p(data_els_p)) u_data_fifo (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .data_i      ({fsm_last_o, fsm_data_i}),
        .v_i         (w_data_push),
        .ready_and_o (w_data_ready),
        .data_o      ({msg_last_o, msg_data_o}),
        .v_o         (msg_data_v_o),
        .ready_and_i (msg_data_ready_and_i)
    );

    bp_me_burst_pump_out_chk #(.header_width_p(hdr_w_lp)) u_chk (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .in_ready_state_i  (w_in_ready),
        .fsm_v_i           (fsm_v_i),
        .fsm_ready_and_i   (fsm_ready_and_o),
        .fsm_base_header_i (fsm_base_header_i)
    );

endmodule

// File: tb/tb_bp_me_burst_pump_out.sv
// Directed bench for the outbound burst pump: single beat, N:N burst, N:1 collapse,
// data/header backpressure and asynchronous reset mid-burst.
module tb_bp_me_burst_pump_out;

    localparam int HW = 63;   // 16 payload + 40 addr + 3 size + 4 type

    logic          clk;
    logic          reset_n_i;
    logic [HW-1:0] fsm_base_header_i;
    logic          fsm_has_data_i;
    logic [63:0]   fsm_data_i;
    logic          fsm_v_i;
    logic          fsm_ready_and_o;
    logic [2:0]    fsm_cnt_o;
    logic [39:0]   fsm_addr_o;
    logic          fsm_new_o;
    logic          fsm_last_o;
    logic [HW-1:0] msg_header_o;
    logic          msg_header_v_o;
    logic          msg_header_ready_and_i;
    logic          msg_has_data_o;
    logic [63:0]   msg_data_o;
    logic          msg_data_v_o;
    logic          msg_data_ready_and_i;
    logic          msg_last_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] hq[$];
    logic        hdq[$];
    logic [63:0] dq[$];
    logic        lq[$];

    bp_me_burst_pump_out #(
        .paddr_width_p(40), .stream_data_width_p(64), .block_width_p(512), .payload_width_p(16),
        .msg_stream_mask_p(16'h0002), .fsm_stream_mask_p(16'h0006),
        .header_els_p(2), .data_els_p(4)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .fsm_base_header_i(fsm_base_header_i), .fsm_has_data_i(fsm_has_data_i),
        .fsm_data_i(fsm_data_i), .fsm_v_i(fsm_v_i), .fsm_ready_and_o(fsm_ready_and_o),
        .fsm_cnt_o(fsm_cnt_o), .fsm_addr_o(fsm_addr_o), .fsm_new_o(fsm_new_o),
        .fsm_last_o(fsm_last_o), .msg_header_o(msg_header_o), .msg_header_v_o(msg_header_v_o),
        .msg_header_ready_and_i(msg_header_ready_and_i), .msg_has_data_o(msg_has_data_o),
        .msg_data_o(msg_data_o), .msg_data_v_o(msg_data_v_o),
        .msg_data_ready_and_i(msg_data_ready_and_i), .msg_last_o(msg_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every handshake on both output channels.
    always @(posedge clk) begin
        if (msg_header_v_o && msg_header_ready_and_i) begin
            hq.push_back({1'b0, msg_header_o});
            hdq.push_back(msg_has_data_o);
        end
        if (msg_data_v_o && msg_data_ready_and_i) begin
            dq.push_back(msg_data_o);
            lq.push_back(msg_last_o);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_hdr(input logic [3:0] typ, input logic [2:0] size,
                                              input logic [39:0] addr, input logic [15:0] pl);
        return {pl, addr, size, typ};
    endfunction

    task automatic clr_q();
        hq.delete(); hdq.delete(); dq.delete(); lq.delete();
    endtask

    // Present one beat, wait (bounded) for acceptance, check FSM-side strobes, then handshake.
    task automatic send_beat(input string tag, input logic [HW-1:0] hdr, input logic hd,
                             input logic [63:0] d, input logic [39:0] e_addr,
                             input logic [2:0] e_cnt, input logic e_new, input logic e_last);
        int n;
        fsm_base_header_i = hdr;
        fsm_has_data_i    = hd;
        fsm_data_i        = d;
        fsm_v_i           = 1'b1;
        #1;
        n = 0;
        while (!fsm_ready_and_o && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"},  {63'd0, fsm_ready_and_o}, 64'd1);
        check({tag, "_addr"}, {24'd0, fsm_addr_o}, {24'd0, e_addr});
        check({tag, "_cnt"},  {61'd0, fsm_cnt_o}, {61'd0, e_cnt});
        check({tag, "_new"},  {63'd0, fsm_new_o}, {63'd0, e_new});
        check({tag, "_last"}, {63'd0, fsm_last_o}, {63'd0, e_last});
        @(posedge clk); #1;
        fsm_v_i = 1'b0;
    endtask

    logic [39:0] burst_addr[8];
    logic [HW-1:0] h;
    logic [HW-1:0] rh[3];

    initial begin
        burst_addr = '{40'h1018, 40'h1020, 40'h1028, 40'h1030,
                       40'h1038, 40'h1000, 40'h1008, 40'h1010};
        reset_n_i = 1'b0;
        fsm_base_header_i = '0; fsm_has_data_i = 1'b0; fsm_data_i = 64'd0; fsm_v_i = 1'b0;
        msg_header_ready_and_i = 1'b1; msg_data_ready_and_i = 1'b1;
        #3;
        check("rst_hdr_v",  {63'd0, msg_header_v_o}, 64'd0);
        check("rst_data_v", {63'd0, msg_data_v_o}, 64'd0);
        check("rst_ready",  {63'd0, fsm_ready_and_o}, 64'd0);
        check("rst_cnt",    {61'd0, fsm_cnt_o}, 64'd0);
        #19 reset_n_i = 1'b1;
        @(posedge clk); #1;

        // Single-beat uncached write, 8B.
        clr_q();
        h = mk_hdr(4'd0, 3'd3, 40'h2000, 16'h00A1);
        send_beat("uc", h, 1'b1, 64'hDEAD, 40'h2000, 3'd0, 1'b1, 1'b1);
        check("uc_lat_hv", {63'd0, msg_header_v_o}, 64'd1);
        check("uc_lat_dv", {63'd0, msg_data_v_o}, 64'd1);
        repeat (2) @(posedge clk); #1;
        check("uc_nh", hq.size(), 64'd1);
        check("uc_nd", dq.size(), 64'd1);
        if (hq.size() == 1 && dq.size() == 1) begin
            check("uc_hdr",  hq[0], {1'b0, h});
            check("uc_hasd", {63'd0, hdq[0]}, 64'd1);
            check("uc_data", dq[0], 64'hDEAD);
            check("uc_lastf", {63'd0, lq[0]}, 64'd1);
        end

        // N:N burst, 64B at 0x1018 with wrap.
        clr_q();
        h = mk_hdr(4'd1, 3'd6, 40'h1018, 16'h00B2);
        for (int i = 0; i < 8; i++)
            send_beat($sformatf("bu%0d", i), h, 1'b1, 64'h1000 + 64'(i), burst_addr[i],
                      3'(i), (i == 0), (i == 7));
        repeat (3) @(posedge clk); #1;
        check("bu_nh", hq.size(), 64'd1);
        check("bu_nd", dq.size(), 64'd8);
        if (dq.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("bu_d%0d", i), dq[i], 64'h1000 + 64'(i));
                check($sformatf("bu_l%0d", i), {63'd0, lq[i]}, {63'd0, (i == 7)});
            end
        end

        // N:1 collapse, 64B at 0x2040: eight beats in, one header out, no data.
        clr_q();
        h = mk_hdr(4'd2, 3'd6, 40'h2040, 16'h00C3);
        for (int i = 0; i < 8; i++)
            send_beat($sformatf("co%0d", i), h, 1'b0, 64'h2000 + 64'(i), 40'h2040 + 40'(8 * i),
                      3'(i), (i == 0), (i == 7));
        repeat (3) @(posedge clk); #1;
        check("co_nh", hq.size(), 64'd1);
        check("co_nd", dq.size(), 64'd0);
        if (hq.size() == 1) begin
            check("co_hdr",  hq[0], {1'b0, h});
            check("co_hasd", {63'd0, hdq[0]}, 64'd0);
        end

        // Data backpressure: four-entry data buffer fills, producer stalls, release drains all.
        clr_q();
        msg_data_ready_and_i = 1'b0;
        h = mk_hdr(4'd1, 3'd6, 40'h1000, 16'h00D4);
        for (int i = 0; i < 4; i++)
            send_beat($sformatf("bp%0d", i), h, 1'b1, 64'h3000 + 64'(i), 40'h1000 + 40'(8 * i),
                      3'(i), (i == 0), 1'b0);
        fsm_data_i = 64'h3004; fsm_v_i = 1'b1; #1;
        check("bp_stall0", {63'd0, fsm_ready_and_o}, 64'd0);
        repeat (2) @(posedge clk); #1;
        check("bp_stall1", {63'd0, fsm_ready_and_o}, 64'd0);
        check("bp_none", dq.size(), 64'd0);
        msg_data_ready_and_i = 1'b1;
        for (int i = 4; i < 8; i++)
            send_beat($sformatf("bp%0d", i), h, 1'b1, 64'h3000 + 64'(i), 40'h1000 + 40'(8 * i),
                      3'(i), 1'b0, (i == 7));
        repeat (4) @(posedge clk); #1;
        check("bp_nd", dq.size(), 64'd8);
        if (dq.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("bp_d%0d", i), dq[i], 64'h3000 + 64'(i));
                check($sformatf("bp_l%0d", i), {63'd0, lq[i]}, {63'd0, (i == 7)});
            end
        end

        // Header backpressure: two headers buffer, the third request stalls.
        clr_q();
        msg_header_ready_and_i = 1'b0;
        for (int i = 0; i < 3; i++)
            rh[i] = mk_hdr(4'd3, 3'd3, 40'h4000 + 40'(64 * i), 16'h0E00 + 16'(i));
        send_beat("hr0", rh[0], 1'b0, 64'd0, 40'h4000, 3'd0, 1'b1, 1'b1);
        send_beat("hr1", rh[1], 1'b0, 64'd0, 40'h4040, 3'd0, 1'b1, 1'b1);
        fsm_base_header_i = rh[2]; fsm_v_i = 1'b1; #1;
        check("hr_stall0", {63'd0, fsm_ready_and_o}, 64'd0);
        repeat (2) @(posedge clk); #1;
        check("hr_stall1", {63'd0, fsm_ready_and_o}, 64'd0);
        msg_header_ready_and_i = 1'b1;
        send_beat("hr2", rh[2], 1'b0, 64'd0, 40'h4080, 3'd0, 1'b1, 1'b1);
        repeat (4) @(posedge clk); #1;
        check("hr_nh", hq.size(), 64'd3);
        if (hq.size() == 3) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("hr_h%0d", i), hq[i], {1'b0, rh[i]});
        end

        // Asynchronous reset in the middle of a burst.
        msg_data_ready_and_i = 1'b0;
        h = mk_hdr(4'd1, 3'd6, 40'h1000, 16'h00F5);
        for (int i = 0; i < 4; i++)
            send_beat($sformatf("rs%0d", i), h, 1'b1, 64'h5000 + 64'(i), 40'h1000 + 40'(8 * i),
                      3'(i), (i == 0), 1'b0);
        fsm_data_i = 64'h5004; fsm_v_i = 1'b1; #1;
        check("rs_pre_dv", {63'd0, msg_data_v_o}, 64'd1);
        #2;
        reset_n_i = 1'b0;
        fsm_v_i   = 1'b0;
        #1;
        check("rs_dv",  {63'd0, msg_data_v_o}, 64'd0);
        check("rs_hv",  {63'd0, msg_header_v_o}, 64'd0);
        check("rs_rdy", {63'd0, fsm_ready_and_o}, 64'd0);
        check("rs_cnt", {61'd0, fsm_cnt_o}, 64'd0);
        #12;
        reset_n_i = 1'b1;
        msg_data_ready_and_i = 1'b1;
        clr_q();
        repeat (3) @(posedge clk); #1;
        check("rs_stale_h", hq.size(), 64'd0);
        check("rs_stale_d", dq.size(), 64'd0);
        h = mk_hdr(4'd0, 3'd3, 40'h3008, 16'h0A5A);
        send_beat("rs_post", h, 1'b1, 64'hBEEF, 40'h3008, 3'd0, 1'b1, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("rs_nh", hq.size(), 64'd1);
        check("rs_nd", dq.size(), 64'd1);
        if (hq.size() == 1 && dq.size() == 1) begin
            check("rs_hdr",   hq[0], {1'b0, h});
            check("rs_data",  dq[0], 64'hBEEF);
            check("rs_lastf", {63'd0, lq[0]}, 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
